// File: rtl/game_state_controller.sv
// Breakout-style game sequencer: start/serve/play/miss/over flow, BCD score and lives.
// Frame timing comes from rising edges of vsync; every update is on the rising edge of clk.
module game_state_controller #(
  parameter int unsigned INIT_LIVES   = 3,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned MISS_FRAMES  = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       start,
  input  logic       brick_hit,
  input  logic       ball_lost,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic [3:0] lives,
  output logic       ball_enable,
  output logic       serve,
  output logic       game_over
);

  // state    | meaning
  // ST_IDLE  | powered up, waiting for a start press
  // ST_SERVE | ball parked at centre, counting SERVE_FRAMES frame ticks
  // ST_PLAY  | ball live; bricks score, a lost ball costs a life
  // ST_MISS  | pause after a lost ball, counting MISS_FRAMES frame ticks
  // ST_OVER  | no lives left, waiting for a fresh start press
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_MISS  = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic [7:0] SERVE_TC   = 8'(SERVE_FRAMES);
  localparam logic [7:0] MISS_TC    = 8'(MISS_FRAMES);
  localparam logic [3:0] LIVES_INIT = 4'(INIT_LIVES);

  state_t     state;
  state_t     state_nxt;
  logic       vsync_q;
  logic       start_q;
  logic       frame_tick;
  logic       start_edge;
  logic [7:0] frame_cnt;
  logic [7:0] frame_inc;
  logic       serve_done;
  logic       miss_done;
  logic       score_max;

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      vsync_q <= vsync;
      start_q <= start;
    end
  end

  assign frame_tick = vsync & ~vsync_q;
  assign start_edge = start & ~start_q;
  assign frame_inc  = frame_cnt + 8'd1;
  assign serve_done = frame_tick && (frame_inc == SERVE_TC);
  assign miss_done  = frame_tick && (frame_inc == MISS_TC);
  assign score_max  = (score1 == 4'd9) && (score0 == 4'd9);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_OVER: begin
        if (start_edge) state_nxt = ST_SERVE;
      end
      ST_SERVE: begin
        if (serve_done) state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        if (ball_lost) state_nxt = (lives <= 4'd1) ? ST_OVER : ST_MISS;
      end
      ST_MISS: begin
        if (miss_done) state_nxt = ST_SERVE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ball_enable = (state == ST_PLAY);
    game_over   = (state == ST_OVER);
  end

  // serve is registered so it lines up with the first cycle of every SERVE visit
  always_ff @(posedge clk) begin
    if (reset) begin
      serve <= 1'b0;
    end else begin
      serve <= (state_nxt == ST_SERVE) && (state != ST_SERVE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      score0    <= 4'd0;
      score1    <= 4'd0;
      lives     <= LIVES_INIT;
      frame_cnt <= 8'd0;
    end else begin
      case (state)
        ST_IDLE, ST_OVER: begin
          if (start_edge) begin
            score0    <= 4'd0;
            score1    <= 4'd0;
            lives     <= LIVES_INIT;
            frame_cnt <= 8'd0;
          end
        end
        ST_SERVE: begin
          if (frame_tick) frame_cnt <= serve_done ? 8'd0 : frame_inc;
        end
        ST_PLAY: begin
          if (brick_hit && !score_max) begin
            if (score0 == 4'd9) begin
              score0 <= 4'd0;
              score1 <= score1 + 4'd1;
            end else begin
              score0 <= score0 + 4'd1;
            end
          end
          if (ball_lost) begin
            lives     <= (lives != 4'd0) ? lives - 4'd1 : 4'd0;
            frame_cnt <= 8'd0;
          end
        end
        ST_MISS: begin
          if (frame_tick) frame_cnt <= miss_done ? 8'd0 : frame_inc;
        end
        default: frame_cnt <= 8'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_game_state_controller.sv
// Directed bench for game_state_controller: a vector table walks one full game,
// then hand sequences cover the simultaneous hit/loss, held start and mid-game reset.
module tb_game_state_controller;

  logic       clk;
  logic       reset;
  logic       vsync;
  logic       start;
  logic       brick_hit;
  logic       ball_lost;
  logic [3:0] score0;
  logic [3:0] score1;
  logic [3:0] lives;
  logic       ball_enable;
  logic       serve;
  logic       game_over;

  int checks = 0;
  int errors = 0;

  game_state_controller #(
    .INIT_LIVES  (3),
    .SERVE_FRAMES(60),
    .MISS_FRAMES (30)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .vsync      (vsync),
    .start      (start),
    .brick_hit  (brick_hit),
    .ball_lost  (ball_lost),
    .score0     (score0),
    .score1     (score1),
    .lives      (lives),
    .ball_enable(ball_enable),
    .serve      (serve),
    .game_over  (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each row is applied reps times; with gap set, every repetition is preceded by a
  // quiet cycle so vsync and the event inputs form separate one-cycle pulses.
  typedef struct {
    logic       rst;
    logic       vs;
    logic       st;
    logic       bh;
    logic       bl;
    int         reps;
    logic       gap;
    logic [3:0] s1;
    logic [3:0] s0;
    logic [3:0] lv;
    logic       be;
    logic       sv;
    logic       go;
  } vec_t;

  vec_t tbl[21];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic rs, input logic vs, input logic st, input logic bh, input logic bl);
    reset     = rs;
    vsync     = vs;
    start     = st;
    brick_hit = bh;
    ball_lost = bl;
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, start, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, start, 1'b0, 1'b0);
    end
  endtask

  task automatic hit();
    cyc(1'b0, 1'b0, start, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, start, 1'b1, 1'b0);
  endtask

  task automatic lose();
    cyc(1'b0, 1'b0, start, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, start, 1'b0, 1'b1);
  endtask

  task automatic chk(input string nm, input logic [3:0] s1, input logic [3:0] s0,
                     input logic [3:0] lv, input logic be, input logic sv, input logic go);
    logic [14:0] got;
    logic [14:0] exp;
    got = {score1, score0, lives, ball_enable, serve, game_over};
    exp = {s1, s0, lv, be, sv, go};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got score=%0d%0d lives=%0d ball_enable=%b serve=%b game_over=%b, want score=%0d%0d lives=%0d ball_enable=%b serve=%b game_over=%b",
               nm, score1, score0, lives, ball_enable, serve, game_over, s1, s0, lv, be, sv, go);
    end
  endtask

  initial begin
    reset = 1'b1; vsync = 1'b0; start = 1'b0; brick_hit = 1'b0; ball_lost = 1'b0;

    //          rst vs st bh bl reps gap  s1 s0 lv be sv go
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  1, 1'b0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  1, 1'b0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  1, 1'b0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  1, 1'b0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1,  1, 1'b0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 59, 1'b1, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  1, 1'b1, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10, 1'b1, 4'd1, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 89, 1'b1, 4'd9, 4'd9, 4'd3, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  1, 1'b1, 4'd9, 4'd9, 4'd3, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1, 1'b1, 4'd9, 4'd9, 4'd2, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 29, 1'b1, 4'd9, 4'd9, 4'd2, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  1, 1'b1, 4'd9, 4'd9, 4'd2, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  1, 1'b0, 4'd9, 4'd9, 4'd2, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 60, 1'b1, 4'd9, 4'd9, 4'd2, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1, 1'b1, 4'd9, 4'd9, 4'd1, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 30, 1'b1, 4'd9, 4'd9, 4'd1, 1'b0, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 60, 1'b1, 4'd9, 4'd9, 4'd1, 1'b1, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1,  1, 1'b1, 4'd9, 4'd9, 4'd0, 1'b0, 1'b0, 1'b1};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1,  1, 1'b1, 4'd9, 4'd9, 4'd0, 1'b0, 1'b0, 1'b1};
    tbl[20] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  1, 1'b0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b1, 1'b0};

    for (int r = 0; r < 21; r++) begin
      for (int k = 0; k < tbl[r].reps; k++) begin
        if (tbl[r].gap) cyc(1'b0, 1'b0, start, 1'b0, 1'b0);
        cyc(tbl[r].rst, tbl[r].vs, tbl[r].st, tbl[r].bh, tbl[r].bl);
      end
      chk($sformatf("table row %0d", r), tbl[r].s1, tbl[r].s0, tbl[r].lv,
          tbl[r].be, tbl[r].sv, tbl[r].go);
    end

    // Last life lost on the same cycle as a brick, with start already held high.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("seqA reset", 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("seqA serve pulse", 4'd0, 4'd0, 4'd3, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(60);
    chk("seqA play", 4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) hit();
    chk("seqA score 09", 4'd0, 4'd9, 4'd3, 1'b1, 1'b0, 1'b0);
    lose();
    ticks(30);
    chk("seqA re-serve", 4'd0, 4'd9, 4'd2, 1'b0, 1'b1, 1'b0);
    ticks(60);
    lose();
    chk("seqA lives 1 miss", 4'd0, 4'd9, 4'd1, 1'b0, 1'b0, 1'b0);
    ticks(90);
    chk("seqA last life play", 4'd0, 4'd9, 4'd1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("seqA hit+lost together", 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("seqA held start no restart", 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("seqA start released", 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("seqA restart", 4'd0, 4'd0, 4'd3, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a SERVE count and in the middle of PLAY.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(20);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("seqB reset mid-serve", 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("seqB brick in idle", 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("seqB start after reset", 4'd0, 4'd0, 4'd3, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(59);
    chk("seqB counter cleared", 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0);
    ticks(1);
    chk("seqB play after 60", 4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) hit();
    chk("seqB score 03", 4'd0, 4'd3, 4'd3, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("seqB reset mid-play", 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
